// File: rtl/regfile_bank_reader.sv
// Read-side drain engine for one bank of the double-banked register file.
// Reads 2-entry blocks through both ports and emits each block as one valid/ready beat.
module regfile_bank_reader #(
    parameter int PORT_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    startBank_i,
    input  logic [ADDR_WIDTH-1:0]   numBlocks_i,
    output logic                    readBank_o,
    output logic [ADDR_WIDTH-1:0]   readAddr0_o,
    output logic [ADDR_WIDTH-1:0]   readAddr1_o,
    input  logic [PORT_WIDTH-1:0]   readData0_i,
    input  logic [PORT_WIDTH-1:0]   readData1_i,
    output logic [2*PORT_WIDTH-1:0] outData_o,
    output logic                    outValid_o,
    input  logic                    outReady_i,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int MAX_BLOCKS = 2 ** (ADDR_WIDTH - 1);
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]              state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    bank_q;
    logic [ADDR_WIDTH-1:0]   nblk_q;
    logic [ADDR_WIDTH-1:0]   blk_q;
    logic [ADDR_WIDTH-1:0]   addr0_q, addr1_q;
    logic [READ_LATENCY-1:0] sr_q;
    logic [READ_LATENCY:0]   sr_d;

    logic [2*PORT_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    accept_start, issue, last_issue, push, pop, credit_ok, drain_finish;
    logic [ADDR_WIDTH-1:0]   nblk_clamped;
    logic [7:0]              inflight;

    assign outValid_o  = (count_q != '0);
    assign outData_o   = fifo_mem_q[rd_ptr_q];
    assign readBank_o  = bank_q;
    assign readAddr0_o = addr0_q;
    assign readAddr1_o = addr1_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    assign nblk_clamped = (numBlocks_i > ADDR_WIDTH'(MAX_BLOCKS)) ? ADDR_WIDTH'(MAX_BLOCKS) : numBlocks_i;
    assign accept_start = (state_q == ST_IDLE) && start_i;
    assign pop          = outValid_o && outReady_i;
    assign push         = sr_q[READ_LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + 8'(sr_q[i]);
        end
    end

    // A slot freed by this cycle's pop counts as credit, so depth READ_LATENCY+1 streams 1 beat/cycle.
    assign credit_ok    = (8'(count_q) + inflight) < (8'(FIFO_DEPTH) + 8'(pop));
    assign issue        = (state_q == ST_READ) && (blk_q < nblk_q) && credit_ok;
    assign last_issue   = issue && ((blk_q + ADDR_WIDTH'(1)) == nblk_q);
    assign drain_finish = (state_q == ST_DRAIN) && pop && (count_q == CNT_W'(1)) && (inflight == 8'd0);
    assign sr_d         = {sr_q, issue};

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_start) begin
                    if (nblk_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (last_issue) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_finish) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bank_q  <= 1'b0;
            nblk_q  <= '0;
            blk_q   <= '0;
            addr0_q <= '0;
            addr1_q <= ADDR_WIDTH'(1);
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (accept_start) begin
                bank_q <= startBank_i;
                nblk_q <= nblk_clamped;
                blk_q  <= '0;
            end
            if (issue) begin
                addr0_q <= {blk_q[ADDR_WIDTH-2:0], 1'b0};
                addr1_q <= {blk_q[ADDR_WIDTH-2:0], 1'b1};
                blk_q   <= blk_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Valid tag travels alongside the read so data is captured exactly READ_LATENCY edges after issue.
    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_vld_pipe
            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) sr_q[gi] <= 1'b0;
                else         sr_q[gi] <= sr_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= {readData1_i, readData0_i};
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
